// File: rtl/mul4x4_seq_ctrl_if.sv
// Request-side handshake between a datapath and the sequential 4x4 multiplier controller.
// The master modport is the requester; the slave modport is the controller.
interface mul4x4_seq_ctrl_if;
  logic       start;
  logic [3:0] x;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic [7:0] product;

  modport master (output start, output x, output y,
                  input busy, input done, input product);
  modport slave  (input start, input x, input y,
                  output busy, output done, output product);
endinterface

// File: rtl/mul4x4_seq_ctrl.sv
// Computes a 4x4 unsigned product by stepping one shared 2x2 multiplier core through
// four digit pairs and shift-accumulating its result into an 8-bit product.
module mul4x4_seq_ctrl #(
  parameter int CORE_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  mul4x4_seq_ctrl_if.slave        req,
  output logic                    mul_a,
  output logic                    mul_b,
  output logic                    mul_c,
  output logic                    mul_d,
  input  logic [3:0]              mul_f
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] xr;
  logic [3:0] yr;
  logic [7:0] acc;
  logic [1:0] k;
  logic [1:0] wait_cnt;
  logic [7:0] term;
  logic [7:0] sum;

  // Step k selects the X digit with k[1] and the Y digit with k[0].
  function automatic logic [3:0] digit_pair(input logic [1:0] step,
                                            input logic [3:0] xv,
                                            input logic [3:0] yv);
    logic [1:0] xd;
    logic [1:0] yd;
    xd = step[1] ? xv[3:2] : xv[1:0];
    yd = step[0] ? yv[3:2] : yv[1:0];
    return {xd, yd};
  endfunction

  always_comb begin
    case (k)
      2'd0:    term = {4'b0000, mul_f};
      2'd3:    term = {mul_f, 4'b0000};
      default: term = {2'b00, mul_f, 2'b00};
    endcase
  end

  assign sum = acc + term;

  // Core inputs are registered one edge ahead so they are stable for the whole step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      xr          <= 4'd0;
      yr          <= 4'd0;
      acc         <= 8'd0;
      k           <= 2'd0;
      wait_cnt    <= 2'd0;
      req.busy    <= 1'b0;
      req.done    <= 1'b0;
      req.product <= 8'd0;
      {mul_a, mul_b, mul_c, mul_d} <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          req.busy <= 1'b0;
          req.done <= 1'b0;
          {mul_a, mul_b, mul_c, mul_d} <= 4'b0000;
          if (req.start) begin
            xr       <= req.x;
            yr       <= req.y;
            acc      <= 8'd0;
            k        <= 2'd0;
            wait_cnt <= 2'd0;
            req.busy <= 1'b1;
            {mul_a, mul_b, mul_c, mul_d} <= digit_pair(2'd0, req.x, req.y);
            state    <= CALC;
          end
        end
        CALC: begin
          if (wait_cnt == 2'(CORE_LAT)) begin
            wait_cnt <= 2'd0;
            acc      <= sum;
            if (k == 2'd3) begin
              req.product <= sum;
              req.done    <= 1'b1;
              {mul_a, mul_b, mul_c, mul_d} <= 4'b0000;
              state       <= DONE;
            end else begin
              k <= k + 2'd1;
              {mul_a, mul_b, mul_c, mul_d} <= digit_pair(k + 2'd1, xr, yr);
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE: begin
          req.done <= 1'b0;
          req.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4x4_seq_ctrl.sv
// Self-checking bench for mul4x4_seq_ctrl: two instances (CORE_LAT 0 and 2) driven by
// randomized operands and three interchangeable 2x2 core models, checked against x*y.
module tb_mul4x4_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul4x4_seq_ctrl_if rq0();
  mul4x4_seq_ctrl_if rq2();

  logic a0, b0, c0, d0, a2, b2, c2, d2;
  logic [3:0] f0, f2;
  int core_sel;

  int checks = 0;
  int passed = 0;

  logic [3:0] trace [0:15];
  int         trace_len;
  logic [7:0] model_prod [0:1];

  // Three 2x2 core styles: gate equations, decoded minterms, and a mux on the X digit.
  function automatic logic [3:0] core_fn(input int sel, input logic [3:0] in);
    logic a, b, c, d;
    logic [15:0] m;
    logic [3:0] f;
    {a, b, c, d} = in;
    f = 4'd0;
    m = 16'd1 << in;
    case (sel)
      0: f = {a & b & c & d, a & c & ~(b & d), (a & d) ^ (b & c), b & d};
      1: begin
        f[3] = m[15];
        f[2] = m[10] | m[11] | m[14];
        f[1] = m[6] | m[7] | m[9] | m[11] | m[13] | m[14];
        f[0] = m[5] | m[7] | m[13] | m[15];
      end
      default: begin
        case ({a, b})
          2'b00: f = 4'd0;
          2'b01: f = {2'b00, c, d};
          2'b10: f = {1'b0, c, d, 1'b0};
          default: begin
            case ({c, d})
              2'b00:   f = 4'd0;
              2'b01:   f = 4'd3;
              2'b10:   f = 4'd6;
              default: f = 4'd9;
            endcase
          end
        endcase
      end
    endcase
    return f;
  endfunction

  assign f0 = core_fn(core_sel, {a0, b0, c0, d0});
  assign f2 = core_fn(core_sel, {a2, b2, c2, d2});

  mul4x4_seq_ctrl #(.CORE_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(rq0),
    .mul_a(a0), .mul_b(b0), .mul_c(c0), .mul_d(d0), .mul_f(f0));

  mul4x4_seq_ctrl #(.CORE_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(rq2),
    .mul_a(a2), .mul_b(b2), .mul_c(c2), .mul_d(d2), .mul_f(f2));

  task automatic drive(input bit sel2, input logic s, input logic [3:0] xv, input logic [3:0] yv);
    if (sel2) begin
      rq2.start = s; rq2.x = xv; rq2.y = yv;
    end else begin
      rq0.start = s; rq0.x = xv; rq0.y = yv;
    end
  endtask

  function automatic logic obs_done(input bit sel2);
    return sel2 ? rq2.done : rq0.done;
  endfunction

  function automatic logic obs_busy(input bit sel2);
    return sel2 ? rq2.busy : rq0.busy;
  endfunction

  function automatic logic [7:0] obs_prod(input bit sel2);
    return sel2 ? rq2.product : rq0.product;
  endfunction

  function automatic logic [3:0] obs_mul(input bit sel2);
    return sel2 ? {a2, b2, c2, d2} : {a0, b0, c0, d0};
  endfunction

  // Starts one multiply from IDLE, scrambles x/y after acceptance, records the core
  // inputs each CALC cycle, and returns after the following IDLE cycle.
  task automatic run_op(input bit sel2, input logic [3:0] xv, input logic [3:0] yv,
                        output int lat, output logic [7:0] prod,
                        output logic [7:0] prod_before, output bit timeout);
    timeout   = 1'b1;
    lat       = -1;
    prod      = 8'd0;
    trace_len = 0;
    drive(sel2, 1'b1, xv, yv);
    prod_before = obs_prod(sel2);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) drive(sel2, 1'b0, 4'($urandom), 4'($urandom));
      if (obs_done(sel2)) begin
        lat     = i;
        prod    = obs_prod(sel2);
        timeout = 1'b0;
        break;
      end
      if (obs_busy(sel2) && trace_len < 16) begin
        trace[trace_len] = obs_mul(sel2);
        trace_len++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs_busy(s[0]) !== 1'b0) $display("[TB] FAIL reset_busy dut%0d: got %b want 0", s, obs_busy(s[0]));
      else passed++;
      checks++;
      if (obs_done(s[0]) !== 1'b0) $display("[TB] FAIL reset_done dut%0d: got %b want 0", s, obs_done(s[0]));
      else passed++;
      checks++;
      if (obs_prod(s[0]) !== 8'd0) $display("[TB] FAIL reset_product dut%0d: got %0d want 0", s, obs_prod(s[0]));
      else passed++;
      checks++;
      if (obs_mul(s[0]) !== 4'd0) $display("[TB] FAIL reset_mul dut%0d: got %b want 0000", s, obs_mul(s[0]));
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
    model_prod[0] = 8'd0;
    model_prod[1] = 8'd0;
  endtask

  task automatic test_zero();
    int lat; logic [7:0] prod, pb; bit to;
    run_op(1'b0, 4'd0, 4'd0, lat, prod, pb, to);
    checks++;
    if (to !== 1'b0 || lat != 4) $display("[TB] FAIL zero_latency: got %0d (timeout %0d) want 4", lat, to);
    else passed++;
    checks++;
    if (prod !== 8'd0) $display("[TB] FAIL zero_product: got %0d want 0", prod);
    else passed++;
  endtask

  task automatic test_max();
    int lat; logic [7:0] prod, pb; bit to;
    core_sel = 0;
    run_op(1'b0, 4'd15, 4'd15, lat, prod, pb, to);
    model_prod[0] = 8'd225;
    checks++;
    if (to !== 1'b0 || lat != 4) $display("[TB] FAIL max_latency: got %0d (timeout %0d) want 4", lat, to);
    else passed++;
    checks++;
    if (prod !== 8'd225) $display("[TB] FAIL max_product: got %0d want 225", prod);
    else passed++;
    checks++;
    if (trace_len != 4) $display("[TB] FAIL max_trace_len: got %0d want 4", trace_len);
    else passed++;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (trace[s] !== 4'b1111) $display("[TB] FAIL max_mul_step%0d: got %b want 1111", s, trace[s]);
      else passed++;
    end
  endtask

  // Every (x,y) pair for each core style, starting at a random offset, back to back.
  task automatic test_sweep();
    int lat, p, off; logic [7:0] prod, pb, ex; bit to; logic [3:0] xv, yv;
    for (int cs = 0; cs < 3; cs++) begin
      core_sel = cs;
      off = $urandom_range(0, 255);
      for (int n = 0; n < 256; n++) begin
        p  = (n + off) % 256;
        xv = 4'(p >> 4);
        yv = 4'(p);
        ex = {4'b0, xv} * {4'b0, yv};
        run_op(1'b0, xv, yv, lat, prod, pb, to);
        checks++;
        if (to !== 1'b0 || prod !== ex)
          $display("[TB] FAIL sweep_product core%0d %0d*%0d: got %0d want %0d", cs, xv, yv, prod, ex);
        else passed++;
        checks++;
        if (lat != 4) $display("[TB] FAIL sweep_latency core%0d %0d*%0d: got %0d want 4", cs, xv, yv, lat);
        else passed++;
        checks++;
        if (pb !== model_prod[0]) $display("[TB] FAIL sweep_product_hold: got %0d want %0d", pb, model_prod[0]);
        else passed++;
        model_prod[0] = ex;
      end
    end
  endtask

  task automatic test_start_during_busy();
    int done_cnt; logic [7:0] prod;
    core_sel = $urandom_range(0, 2);
    done_cnt = 0;
    prod = 8'd0;
    drive(1'b0, 1'b1, 4'd9, 4'd6);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'($urandom), 4'($urandom));
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd3, 4'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd3, 4'd3);
      if (rq0.done) begin
        done_cnt++;
        prod = rq0.product;
        drive(1'b0, 1'b1, 4'd3, 4'd3);
      end
    end
    model_prod[0] = 8'd54;
    checks++;
    if (done_cnt != 1) $display("[TB] FAIL busy_done_count: got %0d want 1", done_cnt);
    else passed++;
    checks++;
    if (prod !== 8'd54) $display("[TB] FAIL busy_product: got %0d want 54", prod);
    else passed++;
    checks++;
    if (rq0.busy !== 1'b0) $display("[TB] FAIL busy_back_to_idle: got %b want 0", rq0.busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int done_cnt, lat; logic [7:0] prod, pb; bit to;
    done_cnt = 0;
    drive(1'b0, 1'b1, 4'd7, 4'd5);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'($urandom), 4'($urandom));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rq0.busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b want 0", rq0.busy);
    else passed++;
    checks++;
    if (rq0.done !== 1'b0) $display("[TB] FAIL midreset_done: got %b want 0", rq0.done);
    else passed++;
    checks++;
    if (rq0.product !== 8'd0) $display("[TB] FAIL midreset_product: got %0d want 0", rq0.product);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rq0.done) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) $display("[TB] FAIL midreset_no_done: got %0d want 0", done_cnt);
    else passed++;
    model_prod[0] = 8'd0;
    model_prod[1] = 8'd0;
    run_op(1'b0, 4'd2, 4'd3, lat, prod, pb, to);
    checks++;
    if (to !== 1'b0 || prod !== 8'd6) $display("[TB] FAIL midreset_restart: got %0d want 6", prod);
    else passed++;
    model_prod[0] = 8'd6;
  endtask

  task automatic test_wait();
    int lat; logic [7:0] prod, pb; bit to; logic [3:0] ex; int xd, yd;
    core_sel = $urandom_range(0, 2);
    run_op(1'b1, 4'd13, 4'd11, lat, prod, pb, to);
    model_prod[1] = 8'd143;
    checks++;
    if (to !== 1'b0 || lat != 12) $display("[TB] FAIL wait_latency: got %0d (timeout %0d) want 12", lat, to);
    else passed++;
    checks++;
    if (prod !== 8'd143) $display("[TB] FAIL wait_product: got %0d want 143", prod);
    else passed++;
    checks++;
    if (trace_len != 12) $display("[TB] FAIL wait_trace_len: got %0d want 12", trace_len);
    else passed++;
    for (int s = 0; s < 4; s++) begin
      xd = (13 >> (2 * (s / 2))) & 3;
      yd = (11 >> (2 * (s % 2))) & 3;
      ex = {2'(xd), 2'(yd)};
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (trace[s * 3 + c] !== ex)
          $display("[TB] FAIL wait_mul_step%0d_cyc%0d: got %b want %b", s, c, trace[s * 3 + c], ex);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    int lat, want_lat; logic [7:0] prod, pb, ex; bit to, sel2; logic [3:0] xv, yv;
    for (int n = 0; n < 24; n++) begin
      sel2     = n[0];
      core_sel = $urandom_range(0, 2);
      xv       = 4'($urandom);
      yv       = 4'($urandom);
      ex       = {4'b0, xv} * {4'b0, yv};
      want_lat = sel2 ? 12 : 4;
      run_op(sel2, xv, yv, lat, prod, pb, to);
      checks++;
      if (to !== 1'b0 || prod !== ex || lat != want_lat)
        $display("[TB] FAIL random_op dut%0d %0d*%0d: got %0d lat %0d want %0d lat %0d",
                 sel2, xv, yv, prod, lat, ex, want_lat);
      else passed++;
      checks++;
      if (pb !== model_prod[sel2]) $display("[TB] FAIL random_hold dut%0d: got %0d want %0d", sel2, pb, model_prod[sel2]);
      else passed++;
      model_prod[sel2] = ex;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    core_sel = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    test_reset();
    test_zero();
    test_max();
    test_sweep();
    test_start_during_busy();
    test_reset_mid();
    test_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mul4x4_seq_ctrl.md
# mul4x4_seq_ctrl

Sequencing controller that computes a 4-bit × 4-bit unsigned product by time-multiplexing one external 2-bit × 2-bit multiplier core over four partial-product steps. It accepts a start request, drives the core's `a,b,c,d` inputs one digit pair per step, and shift-accumulates the core's `f3..f0` result into an 8-bit product. The core can be any of the existing `with_SSI`, `with_decoder` or `with_MUX` implementations. It sits between a requesting datapath and a single shared multiplier core.

## Interface
- `CORE_LAT`, default 0: extra wait cycles per step before sampling the core result. Legal range is 0..3; use it for registered or slow cores.
- `clk` input 1: single system clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new multiply. Sampled only in IDLE.
- `x` input 4: multiplicand. Latched on the accepting edge.
- `y` input 4: multiplier. Latched on the accepting edge.
- `busy` output 1: high in CALC and DONE.
- `done` output 1: one-cycle pulse; `product` is valid in this cycle.
- `product` output 8: last completed result. Held until the next completion.
- `mul_a` output 1: core `a`, the MSB of the X digit.
- `mul_b` output 1: core `b`, the LSB of the X digit.
- `mul_c` output 1: core `c`, the MSB of the Y digit.
- `mul_d` output 1: core `d`, the LSB of the Y digit.
- `mul_f` input 4: core result `{f3,f2,f1,f0}`. Treated as combinational from `mul_a..mul_d`.

## Operation
- States are IDLE, CALC and DONE. A 2-bit step counter `k` runs 0..3, and a wait counter runs 0..CORE_LAT.
- **IDLE:**
  - `mul_a..mul_d` = 0.
  - `start` = 1 latches `x` and `y` into `xr` and `yr`, clears the accumulator, sets k = 0 and wait = 0, and moves to CALC.
  - Otherwise the block stays in IDLE.
- **CALC:** the digit pair is a pure function of `k` and is registered/glitch-free.
  - k = 0: X = `xr[1:0]`, Y = `yr[1:0]`, shift 0.
  - k = 1: X = `xr[1:0]`, Y = `yr[3:2]`, shift 2.
  - k = 2: X = `xr[3:2]`, Y = `yr[1:0]`, shift 2.
  - k = 3: X = `xr[3:2]`, Y = `yr[3:2]`, shift 4.
  - Drive `{mul_a,mul_b}` = X and `{mul_c,mul_d}` = Y.
  - When wait = CORE_LAT: acc <= acc + (`mul_f` << shift), using 8-bit addition. No overflow is possible (max 225). Then wait <= 0.
    - If k = 3: `product` <= final sum and go to DONE.
    - Otherwise: k <= k + 1.
  - When wait < CORE_LAT: wait <= wait + 1, and the core inputs are held stable.
- **DONE:** `done` = 1 and `busy` = 1. Go unconditionally to IDLE on the next edge.
- `start` in CALC or DONE is ignored. It is not queued.
- Changes on `x` and `y` after the accepting edge have no effect.
- **Reset, including mid-operation:** the next state is IDLE, and the registers clear as follows.
  - `busy` = 0, `done` = 0, `product` = 0.
  - acc = 0, k = 0, wait = 0.
  - `mul_a..mul_d` = 0.
  - Any in-flight result is discarded.

## Timing
- Reset values: every output is 0.
- Start is accepted at edge E0. `busy` rises after E0.
- The core is sampled at the end of each step. Each step lasts CORE_LAT+1 cycles.
- DONE is entered at edge E0 + 4·(CORE_LAT+1). `done` and the new `product` are visible in that cycle:
  - 4 cycles after acceptance for CORE_LAT = 0;
  - 12 cycles for CORE_LAT = 2.
- `busy` falls one edge after DONE is entered.
- The earliest next acceptance is the edge after returning to IDLE. Minimum initiation interval is 4·(CORE_LAT+1) + 2 cycles.
- `product` changes only on the DONE-entry edge or on reset.

## Test plan
- **Reset, then 0×0:** after reset all outputs are 0. With x = 0, y = 0 and a start pulse, `done` pulses at cycle +4 with `product` = 0.
- **Maximum operands:** x = 15, y = 15 with CORE_LAT = 0 gives `done` at +4 with `product` = 225. The `{mul_a..mul_d}` sequence must be 1111, 1111, 1111, 1111, one step per cycle.
- **Exhaustive sweep:** all 256 (x,y) pairs, back-to-back at the minimum interval. Each `done` carries `product` = x·y; check against a reference model for all three core implementations.
- **Start during busy:** x = 9, y = 6 is accepted. Pulse `start` with x = 3, y = 3 in CALC cycle 2 and again in the DONE cycle. Exactly one `done` occurs, with `product` = 54, and the block returns to IDLE.
- **Reset mid-operation:** start x = 7, y = 5, then assert `rst` at step k = 2. On the next cycle `busy` = 0, `done` = 0, `product` = 0 and no `done` follows. A subsequent start with x = 2, y = 3 gives `product` = 6.
- **Wait cycles:** with CORE_LAT = 2, x = 13, y = 11 gives `done` at +12 with `product` = 143. The core inputs must hold stable for 3 cycles per step.
